// File: rtl/dmem_responder.sv
// Data-memory responder: services load/store/fence requests from a word-addressed
// byte-writable SRAM and answers each with a one-cycle mem_ready after a fixed wait.
module dmem_responder #(
    parameter int DEPTH        = 4096,
    parameter int WAIT         = 0,
    parameter int FENCE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int AW = $clog2(DEPTH);

    generate
        if (WAIT < 0 || WAIT > 15 || FENCE_CYCLES < 0 || FENCE_CYCLES > 15) begin : g_bad_wait
            $error("dmem_responder: WAIT and FENCE_CYCLES must be in 0..15");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("dmem_responder: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          fence_q;
    logic          load_q;
    logic          range_q;
    logic [31:0]   data_q;
    logic [31:0]   ram [DEPTH];

    logic          accept;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          unused_inputs;

    assign unused_inputs = ^{mem_spec, mem_instr, mem_addr[1:0]};

    assign accept   = mem_valid && (state_q != BUSY);
    assign word_idx = mem_addr[AW+1:2];
    assign in_range = ({2'b00, mem_addr[31:2]} < 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    cnt_d   = mem_fence ? 4'(FENCE_CYCLES) : 4'(WAIT);
                    state_d = (cnt_d != 4'd0) ? BUSY : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            fence_q <= 1'b0;
            load_q  <= 1'b0;
            range_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                fence_q <= mem_fence;
                load_q  <= !mem_fence && (mem_wstrb == 4'd0);
                range_q <= in_range;
            end
        end
    end

    // SRAM write port: committed on the accept edge; a fence suppresses any strobes.
    always_ff @(posedge clock) begin
        if (reset && accept && !mem_fence && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) begin
                    ram[word_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read; a load right after a store sees the already-committed word.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_q <= 32'd0;
        end else if (accept) begin
            data_q <= ram[word_idx];
        end
    end

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = (mem_ready && load_q && range_q) ? data_q : 32'd0;
    assign mem_error = mem_ready && !fence_q && !range_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (WAIT=0 and WAIT=3) driven by
// directed requests; a negedge monitor pops expected responses and compares.
module tb_dmem_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        a_valid, a_fence, a_spec, a_instr;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wstrb;
    logic        a_ready, a_error;
    logic [31:0] a_rdata;
    logic        b_valid, b_fence, b_spec, b_instr;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_wstrb;
    logic        b_ready, b_error;
    logic [31:0] b_rdata;

    dmem_responder #(.DEPTH(4096), .WAIT(0), .FENCE_CYCLES(2)) u_a (
        .clock(clock), .reset(reset),
        .mem_valid(a_valid), .mem_fence(a_fence), .mem_spec(a_spec), .mem_instr(a_instr),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wstrb(a_wstrb),
        .mem_ready(a_ready), .mem_rdata(a_rdata), .mem_error(a_error)
    );

    dmem_responder #(.DEPTH(4096), .WAIT(3), .FENCE_CYCLES(2)) u_b (
        .clock(clock), .reset(reset),
        .mem_valid(b_valid), .mem_fence(b_fence), .mem_spec(b_spec), .mem_instr(b_instr),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wstrb(b_wstrb),
        .mem_ready(b_ready), .mem_rdata(b_rdata), .mem_error(b_error)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    bit   started = 1'b0;
    bit   done    = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        a_valid = 1'b0; a_fence = 1'b0; a_spec = 1'b0; a_instr = 1'b0;
        a_addr = 32'd0; a_wdata = 32'd0; a_wstrb = 4'd0;
        b_valid = 1'b0; b_fence = 1'b0; b_spec = 1'b0; b_instr = 1'b0;
        b_addr = 32'd0; b_wdata = 32'd0; b_wstrb = 4'd0;
    endtask

    task automatic idle(input int n);
        clear_in();
        repeat (n) step();
    endtask

    // Present a request for one cycle; push the expected response if it will be accepted.
    task automatic issue(input int k, input logic f, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_er,
                         input string nm, input bit push);
        exp_t e;
        if (k == 0) begin
            a_valid = 1'b1; a_fence = f; a_addr = ad; a_wdata = wd; a_wstrb = st;
            a_spec = ad[2]; a_instr = ad[3];
        end else begin
            b_valid = 1'b1; b_fence = f; b_addr = ad; b_wdata = wd; b_wstrb = st;
            b_spec = ad[2]; b_instr = ad[3];
        end
        if (push) begin
            e.cyc   = cyc + 1 + (f ? 2 : ((k == 0) ? 0 : 3));
            e.rdata = exp_rd;
            e.err   = exp_er;
            e.name  = nm;
            if (k == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
        step();
    endtask

    task automatic check(input int k, input logic rdy, input logic [31:0] rd, input logic er);
        exp_t e;
        int   sz;
        sz = (k == 0) ? qa.size() : qb.size();
        if (rdy === 1'b1) begin
            n_cmp++;
            if (sz == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready dut%0d: cyc=%0d rdata=%h err=%0b, required no response",
                         k, cyc, rd, er);
            end else begin
                e = (k == 0) ? qa.pop_front() : qb.pop_front();
                if (cyc != e.cyc || rd !== e.rdata || er !== e.err) begin
                    n_bad++;
                    $display("FAIL %s dut%0d: got cyc=%0d rdata=%h err=%0b, required cyc=%0d rdata=%h err=%0b",
                             e.name, k, cyc, rd, er, e.cyc, e.rdata, e.err);
                end else begin
                    $display("resp %s dut%0d: cyc=%0d rdata=%h err=%0b ok", e.name, k, cyc, rd, er);
                end
            end
        end else begin
            n_cmp++;
            if (rdy !== 1'b0 || rd !== 32'd0 || er !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_outputs dut%0d: cyc=%0d ready=%b rdata=%h err=%b, required 0/0/0",
                         k, cyc, rdy, rd, er);
            end
            if (sz > 0) begin
                e = (k == 0) ? qa[0] : qb[0];
                if (e.cyc < cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s dut%0d: no response by cyc=%0d, required at cyc=%0d",
                             e.name, k, cyc, e.cyc);
                    if (k == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (started) begin
            check(0, a_ready, a_rdata, a_error);
            check(1, b_ready, b_rdata, b_error);
        end
        if (done || cyc > 3000) begin
            n_cmp++;
            if (!done || qa.size() != 0 || qb.size() != 0) begin
                n_bad++;
                $display("FAIL end_of_run: done=%0b pending=%0d, required done=1 pending=0",
                         done, qa.size() + qb.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        clear_in();
        reset = 1'b0;
        step();
        started = 1'b1;
        step();
        reset = 1'b1;
        step();

        // WAIT=0: back-to-back stores/loads, byte strobes, fence, range faults
        issue(0, 1'b0, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, "st_w0", 1);
        issue(0, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "st_40", 1);
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_40", 1);
        issue(0, 1'b0, 32'h0000_0041, 32'h1111_1111, 4'h2, 32'h0, 1'b0, "st_41_b1", 1);
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_11EF, 1'b0, "ld_40_strb", 1);
        issue(0, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, "fence", 1);
        idle(2);
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'hDEAD_11EF, 1'b0, "ld_after_fence", 1);
        issue(0, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h0, 1'b1, "ld_oor", 1);
        issue(0, 1'b0, 32'h0000_4000, 32'h1234_5678, 4'hF, 32'h0, 1'b1, "st_oor", 1);
        issue(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, "ld_w0", 1);
        issue(0, 1'b0, 32'h0000_0043, 32'h7777_7777, 4'h8, 32'h0, 1'b0, "st_43_b3", 1);
        issue(0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h77AD_11EF, 1'b0, "ld_40_b3", 1);
        issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, "ld_oor_top", 1);
        issue(0, 1'b1, 32'h0000_4000, 32'h0, 4'h0, 32'h0, 1'b0, "fence_oor", 1);
        idle(5);

        // WAIT=3: held request is ignored while busy; next request accepted in RESP
        issue(1, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "b_st_10", 1);
        idle(4);
        issue(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "b_ld_10", 1);
        repeat (3) issue(1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h0, 1'b0, "held", 0);
        issue(1, 1'b0, 32'h0000_8000, 32'h0, 4'h0, 32'h0, 1'b1, "b_ld_oor_next", 1);
        idle(6);

        // Reset one cycle after a store is accepted: no response, store stays written
        issue(1, 1'b0, 32'h0000_0080, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0, "b_st_80_dropped", 0);
        clear_in();
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle(6);
        issue(1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0, "b_ld_80_after_rst", 1);
        idle(8);
        done = 1'b1;
    end

endmodule
